// File: rtl/mips_pkg.sv
// Shared MIPS decode constants and the control bundle type.
// Opcodes, funct codes, ULA op codes, alu_op codes, control vector.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SLL = 4'b1000;
  localparam logic [3:0] ALU_SRL = 4'b1001;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  localparam logic [1:0] AOP_ADD   = 2'b00;
  localparam logic [1:0] AOP_SUB   = 2'b01;
  localparam logic [1:0] AOP_FUNCT = 2'b10;

  typedef struct packed {
    logic       wreg;
    logic       wrt_rd;
    logic       alusrc;
    logic [1:0] alu_op;
    logic       rmem;
    logic       wmem;
    logic       br;
    logic       pcbr;
    logic       bj;
    logic       regsrc;
  } ctrl_t;

  localparam ctrl_t CTRL_SAFE  = ctrl_t'(11'b0_0_0_00_0_0_0_0_1_1);
  localparam ctrl_t CTRL_RTYPE = ctrl_t'(11'b1_1_0_10_0_0_0_0_1_1);
  localparam ctrl_t CTRL_LW    = ctrl_t'(11'b1_0_1_00_1_0_0_0_1_0);
  localparam ctrl_t CTRL_SW    = ctrl_t'(11'b0_0_1_00_0_1_0_0_1_1);
  localparam ctrl_t CTRL_BEQ   = ctrl_t'(11'b0_0_0_01_0_0_1_1_1_1);
  localparam ctrl_t CTRL_ADDI  = ctrl_t'(11'b1_0_1_00_0_0_0_0_1_1);
  localparam ctrl_t CTRL_J     = ctrl_t'(11'b0_0_0_00_0_0_0_0_0_1);

endpackage

// File: rtl/mips_adder.sv
// Combinational wrap-around adder: sum = a + b mod 2^DATA_WIDTH.
// Ports: a, b (operands), sum (result, no carry out).
module mips_adder #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/mips_decode_unit.sv
// Single-cycle MIPS control decode, ULA op select, PC+4 and sticky illegal flag.
// Ports: clk, nrst (async, active-high), opcode, funct, pc -> strobes, alu_control, pc_plus4, illegal_op.
module mips_decode_unit
  import mips_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic [5:0]            opcode,
  input  logic [5:0]            funct,
  input  logic [DATA_WIDTH-1:0] pc,
  output logic [DATA_WIDTH-1:0] pc_plus4,
  output logic                  branch,
  output logic                  read_mem,
  output logic                  write_mem,
  output logic                  write_reg,
  output logic                  mux_write_rt_rd,
  output logic                  mux_alu_src_reg_imm,
  output logic [1:0]            alu_op,
  output logic                  mux_branch_jump,
  output logic                  mux_pc_branch,
  output logic                  mux_reg_src_alu_mem,
  output logic [3:0]            alu_control,
  output logic                  illegal_op
);

  localparam logic [DATA_WIDTH-1:0] FOUR = DATA_WIDTH'(4);

  ctrl_t dec;
  ctrl_t ctrl;
  logic  known;

  mips_adder #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_pc_add (
    .a  (pc),
    .b  (FOUR),
    .sum(pc_plus4)
  );

  always_comb begin
    dec   = CTRL_SAFE;
    known = 1'b1;
    unique case (1'b1)
      (opcode == OP_RTYPE): dec = CTRL_RTYPE;
      (opcode == OP_LW):    dec = CTRL_LW;
      (opcode == OP_SW):    dec = CTRL_SW;
      (opcode == OP_BEQ):   dec = CTRL_BEQ;
      (opcode == OP_ADDI):  dec = CTRL_ADDI;
      (opcode == OP_J):     dec = CTRL_J;
      default: begin
        dec   = CTRL_SAFE;
        known = 1'b0;
      end
    endcase
  end

  // Reset overrides decode without waiting for a clock.
  assign ctrl = nrst ? CTRL_SAFE : dec;

  assign write_reg           = ctrl.wreg;
  assign mux_write_rt_rd     = ctrl.wrt_rd;
  assign mux_alu_src_reg_imm = ctrl.alusrc;
  assign alu_op              = ctrl.alu_op;
  assign read_mem            = ctrl.rmem;
  assign write_mem           = ctrl.wmem;
  assign branch              = ctrl.br;
  assign mux_pc_branch       = ctrl.pcbr;
  assign mux_branch_jump     = ctrl.bj;
  assign mux_reg_src_alu_mem = ctrl.regsrc;

  always_comb begin
    alu_control = ALU_ADD;
    unique case (ctrl.alu_op)
      AOP_ADD: alu_control = ALU_ADD;
      AOP_SUB: alu_control = ALU_SUB;
      AOP_FUNCT: begin
        unique case (funct)
          FN_ADD:  alu_control = ALU_ADD;
          FN_SUB:  alu_control = ALU_SUB;
          FN_AND:  alu_control = ALU_AND;
          FN_OR:   alu_control = ALU_OR;
          FN_NOR:  alu_control = ALU_NOR;
          FN_SLT:  alu_control = ALU_SLT;
          FN_SLL:  alu_control = ALU_SLL;
          FN_SRL:  alu_control = ALU_SRL;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      illegal_op <= 1'b0;
    end else if (!known) begin
      illegal_op <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mips_decode_unit.sv
// Directed-vector bench for mips_decode_unit.
// Drives on negedge, samples 1 time unit later.
module tb_mips_decode_unit;

  logic        clk = 1'b0;
  logic        nrst;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        branch;
  logic        read_mem;
  logic        write_mem;
  logic        write_reg;
  logic        mux_write_rt_rd;
  logic        mux_alu_src_reg_imm;
  logic [1:0]  alu_op;
  logic        mux_branch_jump;
  logic        mux_pc_branch;
  logic        mux_reg_src_alu_mem;
  logic [3:0]  alu_control;
  logic        illegal_op;

  int n_cmp = 0;
  int n_bad = 0;

  // wreg, wrt_rd, alusrc, alu_op, rmem, wmem, br, pcbr, bj, regsrc
  logic [10:0] vec;
  assign vec = {write_reg, mux_write_rt_rd, mux_alu_src_reg_imm,
                alu_op, read_mem, write_mem, branch,
                mux_pc_branch, mux_branch_jump, mux_reg_src_alu_mem};

  mips_decode_unit #(.DATA_WIDTH(32)) dut (
    .clk                (clk),
    .nrst               (nrst),
    .opcode             (opcode),
    .funct              (funct),
    .pc                 (pc),
    .pc_plus4           (pc_plus4),
    .branch             (branch),
    .read_mem           (read_mem),
    .write_mem          (write_mem),
    .write_reg          (write_reg),
    .mux_write_rt_rd    (mux_write_rt_rd),
    .mux_alu_src_reg_imm(mux_alu_src_reg_imm),
    .alu_op             (alu_op),
    .mux_branch_jump    (mux_branch_jump),
    .mux_pc_branch      (mux_pc_branch),
    .mux_reg_src_alu_mem(mux_reg_src_alu_mem),
    .alu_control        (alu_control),
    .illegal_op         (illegal_op)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic apply(input logic [5:0] op, input logic [5:0] fn);
    @(negedge clk);
    opcode = op;
    funct  = fn;
    #1;
  endtask

  localparam logic [10:0] V_SAFE = 11'b0_0_0_00_0_0_0_0_1_1;
  localparam logic [10:0] V_RTYP = 11'b1_1_0_10_0_0_0_0_1_1;
  localparam logic [10:0] V_LW   = 11'b1_0_1_00_1_0_0_0_1_0;
  localparam logic [10:0] V_SW   = 11'b0_0_1_00_0_1_0_0_1_1;
  localparam logic [10:0] V_BEQ  = 11'b0_0_0_01_0_0_1_1_1_1;
  localparam logic [10:0] V_ADDI = 11'b1_0_1_00_0_0_0_0_1_1;
  localparam logic [10:0] V_J    = 11'b0_0_0_00_0_0_0_0_0_1;

  logic [5:0] fn_tab [8];
  logic [3:0] ac_tab [8];

  initial begin
    fn_tab = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
               6'b100111, 6'b101010, 6'b000000, 6'b000010};
    ac_tab = '{4'b0010, 4'b0110, 4'b0000, 4'b0001,
               4'b1100, 4'b0111, 4'b1000, 4'b1001};

    nrst   = 1'b1;
    opcode = 6'b100011;
    funct  = 6'b000000;
    pc     = 32'h0;
    #1;
    check("rst_vec", 32'(vec), 32'(V_SAFE));
    check("rst_ill", 32'(illegal_op), 32'd0);
    check("rst_alu", 32'(alu_control), 32'h2);
    @(negedge clk);
    @(negedge clk);
    nrst = 1'b0;
    #1;
    check("lw_vec", 32'(vec), 32'(V_LW));
    check("lw_alu", 32'(alu_control), 32'h2);

    for (int i = 0; i < 8; i++) begin
      apply(6'b000000, fn_tab[i]);
      check($sformatf("r_vec_%0d", i), 32'(vec), 32'(V_RTYP));
      check($sformatf("r_alu_%0d", i), 32'(alu_control),
            32'(ac_tab[i]));
    end
    apply(6'b000000, 6'b111111);
    check("r_alu_ff", 32'(alu_control), 32'h2);
    apply(6'b000000, 6'b001101);
    check("r_alu_halt", 32'(alu_control), 32'h2);

    apply(6'b000100, 6'b100100);
    check("beq_vec", 32'(vec), 32'(V_BEQ));
    check("beq_alu", 32'(alu_control), 32'h6);
    apply(6'b000010, 6'b100100);
    check("j_vec", 32'(vec), 32'(V_J));
    apply(6'b101011, 6'b100010);
    check("sw_vec", 32'(vec), 32'(V_SW));
    check("sw_alu", 32'(alu_control), 32'h2);
    apply(6'b001000, 6'b100010);
    check("addi_vec", 32'(vec), 32'(V_ADDI));
    check("addi_alu", 32'(alu_control), 32'h2);
    check("no_ill", 32'(illegal_op), 32'd0);

    pc = 32'h0040_0000;
    #1;
    check("pc4_a", pc_plus4, 32'h0040_0004);
    pc = 32'hFFFF_FFFC;
    #1;
    check("pc4_wrap", pc_plus4, 32'h0000_0000);
    pc = 32'h7FFF_FFFE;
    #1;
    check("pc4_c", pc_plus4, 32'h8000_0002);

    apply(6'b111111, 6'b100010);
    check("bad_vec", 32'(vec), 32'(V_SAFE));
    check("bad_alu", 32'(alu_control), 32'h2);
    check("ill_pre", 32'(illegal_op), 32'd0);
    @(posedge clk);
    #1;
    check("ill_set", 32'(illegal_op), 32'd1);
    apply(6'b000000, 6'b100000);
    check("after_vec", 32'(vec), 32'(V_RTYP));
    @(posedge clk);
    #1;
    check("ill_hold", 32'(illegal_op), 32'd1);

    #2;
    nrst = 1'b1;
    #1;
    check("ill_clr", 32'(illegal_op), 32'd0);
    check("mid_rst_vec", 32'(vec), 32'(V_SAFE));
    @(negedge clk);
    nrst = 1'b0;
    #1;
    check("rel_vec", 32'(vec), 32'(V_RTYP));
    @(posedge clk);
    #1;
    check("ill_stay0", 32'(illegal_op), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
